interp_out_buffer: RTL and testbench
====================================

INTERP_OUT_BUFFER -- requirements
Module: interp_out_buffer

Interface
REQ-001 Parameter WIDTH, default 16: sample width; matches the interpolator output word.
REQ-002 Parameter DEPTH, default 8: FIFO entries; power of two, range 2..64.
REQ-003 Parameter FRAME_LEN, default 30: clocks per interpolator output frame.
REQ-004 Parameter CAPTURE_PHASE, default 0: phase-counter value at which yin is sampled; range 0..FRAME_LEN-1.
REQ-005 clk30x  in  1: single clock, shared with the interpolator; all logic on the rising edge.
REQ-006 rst  in  1: reset, asynchronous and active-high.
REQ-007 yin  in  WIDTH: interpolated sample from the interpolator's yout; changes only at frame boundaries.
REQ-008 dout  out  WIDTH: head-of-FIFO sample, show-ahead.
REQ-009 dout_valid  out  1: dout holds a valid sample.
REQ-010 dout_ready  in  1: consumer accepts dout this cycle.
REQ-011 level  out  log2(DEPTH)+1: current occupancy, 0..DEPTH.
REQ-012 ovf  out  1: sample-dropped indicator.
REQ-013 ovf_clr  in  1: clears a sticky ovf (used only with STICKY_OVF_EN).

Function
REQ-014 Phase counter SHALL count 0..FRAME_LEN-1 and wrap to 0, advancing every clock from the first edge after reset release; it is aligned to the interpolator's frame because both leave reset on the same edge.
REQ-015 Capture SHALL occur at each edge where phase == CAPTURE_PHASE, except the first such edge after reset, which is suppressed because it would sample the reset value of yin.
REQ-016 With default parameters the first capture SHALL occur at edge 31 after reset release (yin updated at edge 30), then every 30 edges.
REQ-017 Pop SHALL occur at an edge where dout_valid && dout_ready; dout_ready while dout_valid is low SHALL have no effect.
REQ-018 A capture into an empty FIFO SHALL raise dout_valid with dout = captured sample after exactly 1 clock.
REQ-019 dout and dout_valid SHALL be stable while dout_valid && !dout_ready.
REQ-020 Simultaneous capture and pop SHALL both complete; level is unchanged, including when the FIFO is full (no overflow).
REQ-021 Capture while level == DEPTH without a pop SHALL drop the new sample, leave FIFO contents and level unchanged, and assert ovf.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH; level SHALL never exceed DEPTH or go below 0.
REQ-023 Samples SHALL leave in capture order, bit-exact; no arithmetic on data.

Reset
REQ-024 While rst is high: phase = 0, pointers = 0, level = 0, dout_valid = 0, dout = 0, ovf = 0, first-capture suppression re-armed.
REQ-025 Reset asserted mid-operation SHALL discard all buffered samples immediately (asynchronously); sampling restarts per REQ-015 after release.

Configuration
REQ-026 Macro STICKY_OVF_EN: when defined, ovf SHALL stay set after a drop until an edge with ovf_clr high; if a drop and ovf_clr coincide, ovf SHALL remain set.
REQ-027 Without STICKY_OVF_EN: ovf SHALL be a 1-clock pulse on the edge after each drop, and ovf_clr SHALL be ignored.

Verification
REQ-028 Reset release, yin ramps 1,2,3... per frame, dout_ready=1 -> first dout_valid at edge 32 with dout=1, then one sample every 30 clocks; dout is never 0 from the suppressed capture.
REQ-029 dout_ready=0 for 9 frames -> level reaches 8 and the 9th capture is dropped; ovf pulses for 1 clock (macro off) or stays high (macro on); after draining, dout sequence is samples 1..8.
REQ-030 FIFO full, dout_ready=1 on the capture edge -> level stays 8, ovf stays 0, oldest sample is popped.
REQ-031 STICKY_OVF_EN on: ovf set; assert ovf_clr together with a new drop -> ovf stays 1; assert ovf_clr alone -> ovf = 0 on the next clock.
REQ-032 4 samples buffered, assert rst asynchronously between edges -> level=0 and dout_valid=0 immediately; after release, the next capture follows REQ-015/016 timing.
REQ-033 Random dout_ready toggling over 200 frames -> output matches a scoreboard of captured samples, with no duplicates and no losses except flagged drops.

Source files
------------

// File: rtl/interp_out_buffer.sv
// Output FIFO for the 30x interpolator: captures yin once per frame and
// hands samples to a show-ahead valid/ready consumer.
//
// Ports:
//   clk30x      : clock shared with the interpolator
//   rst         : asynchronous active-high reset
//   yin         : interpolator sample (changes on frame boundaries)
//   dout        : head-of-FIFO sample (show-ahead, registered)
//   dout_valid  : dout holds a valid sample
//   dout_ready  : consumer takes dout this cycle
//   level       : occupancy 0..DEPTH (storage plus output register)
//   ovf         : sample dropped indicator
//   ovf_clr     : clears a sticky ovf
//
// Build option: define STICKY_OVF_EN to make ovf sticky until ovf_clr.
// Without it ovf is a one-clock pulse and ovf_clr is ignored.

module interp_out_buffer #(
    parameter int WIDTH         = 16,
    parameter int DEPTH         = 8,
    parameter int FRAME_LEN     = 30,
    parameter int CAPTURE_PHASE = 0
) (
    input  logic                     clk30x,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         yin,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     ovf,
    input  logic                     ovf_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [PW-1:0] LAST_PH = PW'(FRAME_LEN - 1);
    localparam logic [PW-1:0] CAP_PH  = PW'(CAPTURE_PHASE);
    localparam logic [AW:0]   FULL_LV = (AW+1)'(DEPTH);

    logic [PW-1:0]    r_phase;
    logic             r_armed;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [AW:0]      r_cnt;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic             r_ovf;

    logic             w_cap_edge;
    logic             w_cap;
    logic             w_pop;
    logic [AW:0]      w_level;
    logic             w_full;
    logic             w_drop;
    logic             w_wr;
    logic             w_load;
    logic [AW:0]      w_cnt_nxt;

    assign w_cap_edge = (r_phase == CAP_PH);
    // The first capture edge after reset would see the reset value of yin.
    assign w_cap      = w_cap_edge && r_armed;
    assign w_pop      = r_dout_valid && dout_ready;
    // Occupancy counts the output register as one slot.
    assign w_level    = r_cnt + (AW+1)'(r_dout_valid);
    assign w_full     = (w_level == FULL_LV);
    // A pop on the same edge frees a slot, so full+pop is not a drop.
    assign w_drop     = w_cap && w_full && !w_pop;
    assign w_wr       = w_cap && !w_drop;
    // Refill the output register when it is empty or being consumed.
    assign w_load     = (!r_dout_valid || w_pop) && (r_cnt != '0);

    always_comb begin
        w_cnt_nxt = r_cnt;
        unique case ({w_wr, w_load})
            2'b10:   w_cnt_nxt = r_cnt + 1'b1;
            2'b01:   w_cnt_nxt = r_cnt - 1'b1;
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    always_ff @(posedge clk30x or posedge rst) begin
        if (rst) begin
            r_phase <= '0;
            r_armed <= 1'b0;
        end else begin
            r_phase <= (r_phase == LAST_PH) ? '0 : r_phase + 1'b1;
            if (w_cap_edge) begin
                r_armed <= 1'b1;
            end
        end
    end

    // Storage array carries no reset; pointers and count define validity.
    always_ff @(posedge clk30x) begin
        if (w_wr) begin
            r_mem[r_wptr] <= yin;
        end
    end

    always_ff @(posedge clk30x or posedge rst) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_load) begin
                r_rptr <= r_rptr + 1'b1;
            end
            r_cnt <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk30x or posedge rst) begin
        if (rst) begin
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
        end else if (w_load) begin
            r_dout       <= r_mem[r_rptr];
            r_dout_valid <= 1'b1;
        end else if (w_pop) begin
            r_dout_valid <= 1'b0;
        end
    end

`ifdef STICKY_OVF_EN
    // A drop wins over a coincident clear.
    always_ff @(posedge clk30x or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end
`else
    logic w_unused_ovf_clr;
    assign w_unused_ovf_clr = ovf_clr;

    always_ff @(posedge clk30x or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else begin
            r_ovf <= w_drop;
        end
    end
`endif

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign level      = w_level;
    assign ovf        = r_ovf;

endmodule

// File: tb/tb_interp_out_buffer.sv
// Bench for interp_out_buffer: directed frame timing, overflow, reset
// and random back-pressure against a queue scoreboard.

module tb_interp_out_buffer;

    localparam int W     = 16;
    localparam int DEPTH = 8;

    logic          clk30x = 1'b0;
    logic          rst;
    logic [W-1:0]  yin;
    logic [W-1:0]  dout;
    logic          dout_valid;
    logic          dout_ready;
    logic [3:0]    level;
    logic          ovf;
    logic          ovf_clr;

    int            n_chk  = 0;
    int            n_fail = 0;
    int            ecount = 0;
    int            lag    = 0;
    logic          exp_ovf = 1'b0;
    logic [W-1:0]  next_val = 16'd1;
    logic [W-1:0]  exp_first;
    logic [W-1:0]  q [$];

    interp_out_buffer #(
        .WIDTH(W), .DEPTH(DEPTH), .FRAME_LEN(30), .CAPTURE_PHASE(0)
    ) dut (
        .clk30x    (clk30x),
        .rst       (rst),
        .yin       (yin),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .level     (level),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    always #5 clk30x = ~clk30x;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s edge=%0d got=%0h exp=%0h",
                     tag, ecount, got, exp);
        end
    endtask

    // One clock: model update plus per-cycle checks, sampled 1 unit
    // after the edge. yin steps to the next ramp value on frame edges.
    task automatic step();
        logic         pop;
        logic         cap;
        logic         clr;
        logic         drop;
        logic [W-1:0] cv;
        pop = dout_valid && dout_ready;
        cap = (ecount >= 30) && ((ecount % 30) == 0);
        clr = ovf_clr;
        cv  = yin;
        @(posedge clk30x);
        ecount++;
        drop = 1'b0;
        if (pop && q.size() > 0) void'(q.pop_front());
        if (cap) begin
            if (q.size() < DEPTH) q.push_back(cv);
            else drop = 1'b1;
        end
`ifdef STICKY_OVF_EN
        if (drop) exp_ovf = 1'b1;
        else if (clr) exp_ovf = 1'b0;
`else
        exp_ovf = drop;
`endif
        #1;
        if ((ecount % 30) == 0) begin
            yin = next_val;
            next_val++;
        end
        chk("level", 32'(level), 32'(q.size()));
        chk("ovf", 32'(ovf), 32'(exp_ovf));
        if (dout_valid) begin
            if (q.size() == 0) chk("valid_empty", 32'(1), 32'(0));
            else chk("dout", 32'(dout), 32'(q[0]));
        end
        if (q.size() > 0 && !dout_valid) lag++;
        else lag = 0;
        chk("valid_lag", 32'(lag > 1), 32'(0));
    endtask

    task automatic run_to(input int n);
        while (ecount < n) step();
    endtask

    // Reset asserted between edges; outputs must clear at once.
    task automatic async_reset();
        #3;
        rst = 1'b1;
        #1;
        chk("arst_level", 32'(level), 32'(0));
        chk("arst_valid", 32'(dout_valid), 32'(0));
        chk("arst_dout", 32'(dout), 32'(0));
        chk("arst_ovf", 32'(ovf), 32'(0));
        q.delete();
        exp_ovf = 1'b0;
        lag     = 0;
        yin     = '0;
        repeat (2) @(posedge clk30x);
        @(negedge clk30x);
        rst    = 1'b0;
        ecount = 0;
    endtask

    initial begin
        rst        = 1'b1;
        yin        = '0;
        dout_ready = 1'b0;
        ovf_clr    = 1'b0;
        repeat (3) @(posedge clk30x);
        #1;
        chk("rst_level", 32'(level), 32'(0));
        chk("rst_valid", 32'(dout_valid), 32'(0));
        chk("rst_dout", 32'(dout), 32'(0));
        chk("rst_ovf", 32'(ovf), 32'(0));
        @(negedge clk30x);
        rst    = 1'b0;
        ecount = 0;

        // First capture at edge 31, visible at edge 32.
        dout_ready = 1'b1;
        run_to(31);
        chk("cap31_valid", 32'(dout_valid), 32'(0));
        chk("cap31_level", 32'(level), 32'(1));
        run_to(32);
        chk("first_valid", 32'(dout_valid), 32'(1));
        chk("first_dout", 32'(dout), 32'(1));
        run_to(100);

        // Stall: eight captures fill, the ninth (edge 361) drops.
        dout_ready = 1'b0;
        run_to(331);
        chk("full_level", 32'(level), 32'(8));
        run_to(361);
        chk("drop_level", 32'(level), 32'(8));
        chk("drop_ovf", 32'(ovf), 32'(1));
        run_to(362);
`ifdef STICKY_OVF_EN
        chk("ovf_hold", 32'(ovf), 32'(1));
`else
        chk("ovf_pulse_end", 32'(ovf), 32'(0));
`endif

        // Full with a pop on the capture edge: no drop.
        run_to(390);
        dout_ready = 1'b1;
        step();
        dout_ready = 1'b0;
        chk("fullpop_level", 32'(level), 32'(8));
`ifndef STICKY_OVF_EN
        chk("fullpop_ovf", 32'(ovf), 32'(0));
`endif

        // Clear coinciding with a drop, then clear alone.
        run_to(420);
        ovf_clr = 1'b1;
        step();
        chk("clr_drop_ovf", 32'(ovf), 32'(1));
        step();
        chk("clr_alone_ovf", 32'(ovf), 32'(0));
        ovf_clr = 1'b0;

        // Drain in capture order.
        dout_ready = 1'b1;
        run_to(480);
        chk("drained", 32'(level), 32'(0));

        // Four buffered, then asynchronous reset.
        dout_ready = 1'b0;
        run_to(575);
        chk("pre_rst_level", 32'(level), 32'(4));
        async_reset();
        exp_first  = next_val;
        dout_ready = 1'b1;
        run_to(31);
        chk("rst_cap31_valid", 32'(dout_valid), 32'(0));
        run_to(32);
        chk("rst_first_valid", 32'(dout_valid), 32'(1));
        chk("rst_first_dout", 32'(dout), 32'(exp_first));

        // Random back-pressure over 200 frames.
        for (int f = 0; f < 200; f++) begin
            int thr;
            case ((f / 20) % 4)
                0: thr = 6;
                1: thr = 3;
                2: thr = 1;
                default: thr = 0;
            endcase
            for (int c = 0; c < 30; c++) begin
                dout_ready = (($urandom % 8) < 32'(thr));
                ovf_clr    = (($urandom % 16) == 0);
                step();
            end
        end
        ovf_clr    = 1'b0;
        dout_ready = 1'b1;
        repeat (20) step();
        while (q.size() > 0 && ecount < 7000) step();
        chk("final_level", 32'(level), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
